// File: rtl/gmii_rx_framer_if.sv
// Payload stream from gmii_rx_framer to the UDP/IP parser.
// master: framer side (drives), slave: parser side (receives).
//   data_o   payload byte
//   valid_o  data_o valid, one byte per cycle, no back-pressure
//   sof_o    first payload byte of a frame (with valid_o)
//   eof_o    last payload byte of a frame (with valid_o)
//   crc_ok_o FCS check passed (meaningful with eof_o)
//   err_o    frame bad (meaningful with eof_o)
interface gmii_rx_framer_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       sof_o;
  logic       eof_o;
  logic       crc_ok_o;
  logic       err_o;

  modport master (output data_o, valid_o, sof_o, eof_o, crc_ok_o, err_o);
  modport slave  (input  data_o, valid_o, sof_o, eof_o, crc_ok_o, err_o);
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks the CRC-32 FCS, strips the
// four FCS bytes and streams the payload with sof/eof/error markers.
// Ports:
//   rxck_i      receive clock, sole clock
//   rst_i       asynchronous active-high reset
//   rxd_i       GMII receive byte
//   rxctl_lo_i  RX_DV
//   rxctl_hi_i  RX_DV xor RX_ER
//   pl          payload stream (gmii_rx_framer_if.master)
//   good_cnt_o  frames ended without error (wrapping)
//   bad_cnt_o   frames ended with error (wrapping)
module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             rxck_i,
  input  logic             rst_i,
  input  logic [7:0]       rxd_i,
  input  logic             rxctl_lo_i,
  input  logic             rxctl_hi_i,
  gmii_rx_framer_if.master pl,
  output logic [CNT_W-1:0] good_cnt_o,
  output logic [CNT_W-1:0] bad_cnt_o
);

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state, state_nx;
  logic        dv, er;
  logic        start, take, fin;
  logic [39:0] pipe;       // newest byte in [7:0], held byte in [39:32]
  logic [31:0] crc;
  logic [10:0] len;
  logic        er_flag;
  logic        crc_hit, len_bad;

  assign dv      = rxctl_lo_i;
  assign er      = rxctl_lo_i ^ rxctl_hi_i;
  assign crc_hit = (crc == RESIDUE);
  assign len_bad = (len < MIN_L) || (len > MAX_L);

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge rxck_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    take     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: if (dv) state_nx = (rxd_i == 8'h55) ? PRE : DROP;
      PRE: begin
        if (!dv)                  state_nx = IDLE;
        else if (rxd_i == 8'h55)  state_nx = PRE;
        else if (rxd_i == 8'hD5) begin
          state_nx = DATA;
          start    = 1'b1;
        end
        else                      state_nx = DROP;
      end
      DATA: begin
        if (dv) take = 1'b1;
        else begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      DROP: if (!dv) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A byte leaves the pipe once five later bytes exist (four FCS + itself),
  // so len (pre-increment) >= 5 marks the held byte as payload.
  always_ff @(posedge rxck_i or posedge rst_i) begin
    if (rst_i) begin
      pipe        <= '0;
      crc         <= '1;
      len         <= '0;
      er_flag     <= 1'b0;
      pl.data_o   <= '0;
      pl.valid_o  <= 1'b0;
      pl.sof_o    <= 1'b0;
      pl.eof_o    <= 1'b0;
      pl.crc_ok_o <= 1'b0;
      pl.err_o    <= 1'b0;
      good_cnt_o  <= '0;
      bad_cnt_o   <= '0;
    end
    else begin
      pl.valid_o  <= 1'b0;
      pl.sof_o    <= 1'b0;
      pl.eof_o    <= 1'b0;
      pl.crc_ok_o <= 1'b0;
      pl.err_o    <= 1'b0;

      if (pl.eof_o) begin
        if (pl.err_o) bad_cnt_o  <= bad_cnt_o + CNT_W'(1);
        else          good_cnt_o <= good_cnt_o + CNT_W'(1);
      end

      if (start) begin
        crc     <= '1;
        len     <= '0;
        er_flag <= 1'b0;
      end

      if (take) begin
        pipe <= {pipe[31:0], rxd_i};
        crc  <= crc_step(crc, rxd_i);
        if (len != '1) len <= len + 11'd1;
        if (er) er_flag <= 1'b1;
        if (len >= 11'd5) begin
          pl.data_o  <= pipe[39:32];
          pl.valid_o <= 1'b1;
          pl.sof_o   <= (len == 11'd5);
        end
      end

      // Last payload byte is still in the hold slot when dv drops.
      if (fin && len >= 11'd5) begin
        pl.data_o   <= pipe[39:32];
        pl.valid_o  <= 1'b1;
        pl.sof_o    <= (len == 11'd5);
        pl.eof_o    <= 1'b1;
        pl.crc_ok_o <= crc_hit;
        pl.err_o    <= er_flag | ~crc_hit | len_bad;
      end
    end
  end

endmodule

// File: doc/gmii_rx_framer.md
Name: gmii_rx_framer

Overview:
- Receive-side framer that consumes the SDR GMII byte stream produced by the RGMII-to-GMII DDR capture stage, all in the rxck_i domain.
- Strips preamble/SFD, checks CRC-32 (FCS), strips the 4 FCS bytes and delivers payload bytes with sof/eof/error markers to the UDP/IP parser.
- No back-pressure; the downstream block must accept one byte per cycle.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (after SFD, FCS included).
- MAX_LEN, 1518, maximum legal frame length in bytes (after SFD, FCS included).
- CNT_W, 16, width of the frame statistics counters.

Ports:
- rxck_i  in  1  receive clock (125 MHz), sole clock.
- rst_i  in  1  asynchronous active-high reset.
- rxd_i  in  8  GMII receive byte.
- rxctl_lo_i  in  1  rising-edge RGMII ctl sample = RX_DV.
- rxctl_hi_i  in  1  falling-edge RGMII ctl sample = RX_DV xor RX_ER.
- data_o  out  8  payload byte.
- valid_o  out  1  data_o valid.
- sof_o  out  1  first payload byte (qualified by valid_o).
- eof_o  out  1  last payload byte (qualified by valid_o).
- crc_ok_o  out  1  FCS check passed; meaningful only with eof_o.
- err_o  out  1  frame bad; meaningful only with eof_o.
- good_cnt_o  out  CNT_W  frames ended with err_o=0, wrapping.
- bad_cnt_o  out  CNT_W  frames ended with err_o=1, wrapping.

Behaviour:
- Reset: all outputs, counters, buffers and flags are 0; state=IDLE; CRC register=0xFFFFFFFF.
- Signal decode: dv=rxctl_lo_i; er=rxctl_lo_i^rxctl_hi_i. er with dv=0 (false carrier/extension) is ignored.
- FSM transitions:
  - IDLE: dv&&rxd==0x55 -> PRE. dv with any other byte -> DROP.
  - PRE: dv&&0x55 -> PRE. dv&&0xD5 -> DATA, clear CRC/len/err flags. dv with any other byte -> DROP. !dv -> IDLE.
  - DATA: dv -> shift byte into the pipe, update CRC, len++ (11-bit, saturating at 2047), set er_flag if er. !dv -> end-of-frame handling (below), then IDLE.
  - DROP: stay until !dv, then IDLE. DROP produces no output.
- Pipeline: a 5-byte shift buffer (4 FCS + 1 hold).
  - Byte k is emitted (valid_o=1) in the cycle after byte k+5 is sampled.
  - On the first !dv cycle in DATA with len>=5, the held byte is emitted in the next cycle with eof_o=1.
  - Uniform latency: every payload byte appears 6 cycles after it was sampled.
  - sof_o=1 on the first emitted byte of a frame.
  - A frame with len<=4 emits nothing and changes no counter.
- CRC: reflected polynomial 0xEDB88320, LSB-first, init 0xFFFFFFFF, computed over all bytes after SFD including FCS. crc_ok = (register==0xDEBB20E3) at end-of-frame.
- err_o = er_flag | !crc_ok | len<MIN_LEN | len>MAX_LEN. Oversize frames are not truncated.
- Counters: on the eof_o cycle, good_cnt_o++ if err_o=0, else bad_cnt_o++. Counters wrap.
- valid_o, sof_o and eof_o are single-cycle per byte; valid_o=0 outside frames. data_o value is don't-care when valid_o=0.
- Back-to-back frames: a one-cycle dv gap is sufficient. The !dv cycle ends the frame; a 0x55 in the next cycle enters PRE. The eof byte of frame N and frame N+1 preamble processing overlap without interference.
- Reset mid-frame: outputs clear immediately. If dv is still high after release, the remainder is dropped (IDLE sees a non-0x55 byte -> DROP, or tracks preamble correctly if 0x55).

Test Plan:
1. 64-byte frame (60 payload + correct FCS) after 7×0x55+0xD5 -> 60 valid_o bytes matching the input, first byte 6 cycles after sampling, sof_o on byte 0, eof_o on byte 59, crc_ok_o=1, err_o=0, good_cnt_o 0->1.
2. Same frame with payload byte 10 bit 0 flipped -> 60 bytes out, eof with crc_ok_o=0, err_o=1, bad_cnt_o 0->1.
3. Test-1 frame with rxctl_lo_i=1, rxctl_hi_i=0 on payload byte 20 -> crc_ok_o=1, err_o=1, bad_cnt_o increments.
4. 40-byte runt with correct FCS -> 36 bytes out, crc_ok_o=1, err_o=1. Separately, a 1600-byte frame -> 1596 bytes out, err_o=1.
5. Cases with no output and unchanged counters:
   - 3 bytes after SFD.
   - Preamble 0x55,0x5A,... -> DROP.
   - dv low with er high in IDLE.
6. Two test-1 frames with a 1-cycle dv gap -> both delivered, good_cnt_o=2. Then rst_i pulsed at payload byte 30 of a third frame -> outputs 0 immediately, rest of frame dropped; a fourth frame is received correctly with good_cnt_o=1.
